// File: rtl/tmr0_peripheral.sv
// tmr0_peripheral: Timer0 responder on the core's external peripheral bus.
// It holds TMR0 and OPTION_REG and serves reads and writes for both.
// It counts instruction cycles, or an optional external clock, through an
// 8-bit prescaler, and pulses t0if_set when TMR0 overflows.
// Optional feature macro: TMR0_EXT_CLOCK_EN adds the t0cki pin with a
// synchronizer and an edge detector. When the macro is undefined, T0CS=1
// selects a source that never fires.
module tmr0_peripheral #(
    parameter logic [7:0] TMR0_RESET   = 8'h00,
    parameter logic [7:0] OPTION_RESET = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] periph_addr,
    input  logic [7:0] periph_data_in,
    input  logic       periph_wr_en,
    output logic [7:0] periph_data_out,
    input  logic       tcy_tick,
`ifdef TMR0_EXT_CLOCK_EN
    input  logic       t0cki,
`endif
    output logic       t0if_set
);

    logic [7:0] tmr0_q, tmr0_d;
    logic [7:0] option_q, option_d;
    logic [7:0] psc_q, psc_d;
    logic [1:0] inh_q, inh_d;
    logic       t0if_q, t0if_d;

    logic       tmr0_sel, option_sel;
    logic       tmr0_wr, option_wr;
    logic       ext_event, src_event;
    logic [7:0] psc_inc;
    logic [2:0] ps;
    logic       psc_edge;
    logic       inc, count_en;

    // Bit 8 selects the bank pair and is a don't-care for both registers.
    assign tmr0_sel   = (periph_addr ==? 9'b?_0000_0001);
    assign option_sel = (periph_addr ==? 9'b?_1000_0001);
    assign tmr0_wr    = periph_wr_en & tmr0_sel;
    assign option_wr  = periph_wr_en & option_sel;

`ifdef TMR0_EXT_CLOCK_EN
    logic sync1_q, sync2_q, edge_q;

    // Two-flop synchronizer for t0cki, followed by one flop that holds
    // the previous synchronized level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= t0cki;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    // T0SE=1 selects the falling edge; T0SE=0 selects the rising edge.
    assign ext_event = option_q[4] ? (edge_q & ~sync2_q) : (~edge_q & sync2_q);
`else
    assign ext_event = 1'b0;
`endif

    assign src_event = option_q[5] ? ext_event : tcy_tick;
    assign psc_inc   = psc_q + 8'd1;
    assign ps        = option_q[2:0];
    // The selected prescaler bit falling from 1 to 0 gives a 2^(PS+1) ratio.
    assign psc_edge  = psc_q[ps] & ~psc_inc[ps];

    // Next-state logic. A TMR0 write has priority over a same-edge increment.
    always_comb begin
        psc_d    = psc_q;
        inh_d    = inh_q;
        tmr0_d   = tmr0_q;
        t0if_d   = 1'b0;
        option_d = option_q;
        inc      = 1'b0;

        if (src_event) begin
            if (option_q[3]) begin
                inc = 1'b1;
            end else begin
                psc_d = psc_inc;
                inc   = psc_edge;
            end
        end

        if (tcy_tick && (inh_q != 2'd0)) begin
            inh_d = inh_q - 2'd1;
        end

        count_en = inc && (inh_q == 2'd0);

        if (tmr0_wr) begin
            tmr0_d = periph_data_in;
            psc_d  = 8'd0;
            inh_d  = 2'd2;
        end else if (count_en) begin
            tmr0_d = tmr0_q + 8'd1;
            t0if_d = (tmr0_q == 8'hFF);
        end

        if (option_wr) begin
            option_d = periph_data_in;
        end
    end

    // State registers. Reset drops any partial prescale count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr0_q   <= TMR0_RESET;
            option_q <= OPTION_RESET;
            psc_q    <= 8'd0;
            inh_q    <= 2'd0;
            t0if_q   <= 1'b0;
        end else begin
            tmr0_q   <= tmr0_d;
            option_q <= option_d;
            psc_q    <= psc_d;
            inh_q    <= inh_d;
            t0if_q   <= t0if_d;
        end
    end

    // Read mux: combinational, with no side effects; unmapped addresses read as zero.
    always_comb begin
        periph_data_out = 8'h00;
        if (tmr0_sel) begin
            periph_data_out = tmr0_q;
        end else if (option_sel) begin
            periph_data_out = option_q;
        end
    end

    assign t0if_set = t0if_q;

endmodule

// File: tb/tb_tmr0_peripheral.sv
// Testbench for tmr0_peripheral: directed vector table, an asynchronous reset
// sequence, randomized traffic against a reference model, and an external
// clock sequence when TMR0_EXT_CLOCK_EN is defined.
module tb_tmr0_peripheral;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] addr;
  logic [7:0] din;
  logic       wr;
  logic       tick;
  logic       t0cki;
  wire  [7:0] dout;
  wire        t0if;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  tmr0_peripheral #(
    .TMR0_RESET  (8'h00),
    .OPTION_RESET(8'hFF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .periph_addr    (addr),
    .periph_data_in (din),
    .periph_wr_en   (wr),
    .periph_data_out(dout),
    .tcy_tick       (tick),
`ifdef TMR0_EXT_CLOCK_EN
    .t0cki          (t0cki),
`endif
    .t0if_set       (t0if)
  );

  // ---------------- reference model ----------------
  int m_tmr, m_opt, m_psc, m_inh;
  bit m_if;

  function automatic void model_reset();
    m_tmr = 0; m_opt = 255; m_psc = 0; m_inh = 0; m_if = 0;
  endfunction

  function automatic int model_read(input logic [8:0] a);
    if (a[7:0] == 8'h01) return m_tmr;
    if (a[7:0] == 8'h81) return m_opt;
    return 0;
  endfunction

  // One clock edge of the timer, from its rules, with the external source held idle.
  function automatic void model_clock(input logic [8:0] a, input int d, input bit w, input bit t);
    bit ev, inc, blocked;
    int ratio;
    ev  = ((m_opt / 32) % 2 == 0) ? t : 1'b0;
    inc = 0;
    if (ev) begin
      if ((m_opt / 8) % 2 == 1) begin
        inc = 1;
      end else begin
        ratio = 2 << (m_opt % 8);
        m_psc = (m_psc + 1) % 256;
        inc   = (m_psc % ratio) == 0;
      end
    end
    blocked = (m_inh != 0);
    if (t && m_inh > 0) m_inh = m_inh - 1;
    m_if = 0;
    if (w && a[7:0] == 8'h01) begin
      m_tmr = d; m_psc = 0; m_inh = 2;
    end else if (inc && !blocked) begin
      m_if  = (m_tmr == 255);
      m_tmr = (m_tmr + 1) % 256;
    end
    if (w && a[7:0] == 8'h81) m_opt = d;
  endfunction

  // ---------------- driver / checker ----------------
  task automatic step(input logic [8:0] a, input logic [7:0] d, input bit w, input bit t);
    addr = a; din = d; wr = w; tick = t;
    model_clock(a, int'(d), w, t);
    @(posedge clk);
    #1;
    wr = 1'b0; tick = 1'b0;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [8:0] a;
    logic [7:0] d;
    bit         w;
    bit         t;
    logic [7:0] exp_rd;
    bit         exp_if;
  } vec_t;

  vec_t vecs[40];
  int   nv;

  task automatic addv(input logic [8:0] a, input logic [7:0] d, input bit w, input bit t,
                      input logic [7:0] er, input bit ei);
    vecs[nv].a = a; vecs[nv].d = d; vecs[nv].w = w; vecs[nv].t = t;
    vecs[nv].exp_rd = er; vecs[nv].exp_if = ei;
    nv++;
  endtask

  initial begin
    logic [8:0] ra;
    logic [7:0] rd;
    bit         rw, rt;
    int         sel;

    rst = 1'b1; addr = 9'h001; din = 8'h00; wr = 1'b0; tick = 1'b0; t0cki = 1'b0;
    model_reset();
    nv = 0;

    // 1:1 overflow with inhibit
    addv(9'h081, 8'h08, 1, 0, 8'h08, 0);
    addv(9'h001, 8'hFD, 1, 0, 8'hFD, 0);
    addv(9'h001, 8'h00, 0, 1, 8'hFD, 0);
    addv(9'h001, 8'h00, 0, 1, 8'hFD, 0);
    addv(9'h001, 8'h00, 0, 1, 8'hFE, 0);
    addv(9'h001, 8'h00, 0, 1, 8'hFF, 0);
    addv(9'h001, 8'h00, 0, 1, 8'h00, 1);
    addv(9'h001, 8'h00, 0, 0, 8'h00, 0);
    // decode
    addv(9'h101, 8'h00, 0, 0, 8'h00, 0);
    addv(9'h181, 8'h00, 0, 0, 8'h08, 0);
    addv(9'h002, 8'h00, 0, 0, 8'h00, 0);
    addv(9'h002, 8'hAA, 1, 0, 8'h00, 0);
    addv(9'h001, 8'h00, 0, 0, 8'h00, 0);
    addv(9'h081, 8'h00, 0, 0, 8'h08, 0);
    // write vs increment collision at FF
    addv(9'h001, 8'hFE, 1, 0, 8'hFE, 0);
    addv(9'h001, 8'h00, 0, 1, 8'hFE, 0);
    addv(9'h001, 8'h00, 0, 1, 8'hFE, 0);
    addv(9'h001, 8'h00, 0, 1, 8'hFF, 0);
    addv(9'h001, 8'h55, 1, 1, 8'h55, 0);
    addv(9'h001, 8'h00, 0, 0, 8'h55, 0);
    addv(9'h001, 8'h00, 0, 1, 8'h55, 0);
    addv(9'h001, 8'h00, 0, 1, 8'h55, 0);
    addv(9'h001, 8'h00, 0, 1, 8'h56, 0);
    // prescale 1:4
    addv(9'h081, 8'h01, 1, 0, 8'h01, 0);
    addv(9'h001, 8'h00, 1, 0, 8'h00, 0);
    addv(9'h001, 8'h00, 0, 1, 8'h00, 0);
    addv(9'h001, 8'h00, 0, 1, 8'h00, 0);
    addv(9'h001, 8'h00, 0, 1, 8'h00, 0);
    addv(9'h001, 8'h00, 0, 1, 8'h01, 0);
    addv(9'h001, 8'h00, 0, 1, 8'h01, 0);
    addv(9'h001, 8'h00, 0, 1, 8'h01, 0);
    addv(9'h001, 8'h00, 0, 1, 8'h01, 0);
    addv(9'h001, 8'h00, 0, 1, 8'h02, 0);
    // upper-bank writes
    addv(9'h181, 8'hC8, 1, 0, 8'hC8, 0);
    addv(9'h081, 8'h00, 0, 0, 8'hC8, 0);
    addv(9'h101, 8'h3C, 1, 0, 8'h3C, 0);
    addv(9'h001, 8'h00, 0, 0, 8'h3C, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_tmr0", dout, 8'h00);
    check("reset_if", {7'd0, t0if}, 8'h00);
    rst = 1'b0;
    step(9'h081, 8'h00, 0, 0);
    check("reset_option", dout, 8'hFF);

    // Vector table: one tick per instruction cycle (four clocks).
    for (int i = 0; i < nv; i++) begin
      step(vecs[i].a, vecs[i].d, vecs[i].w, vecs[i].t);
      check($sformatf("vec%0d_rd", i), dout, vecs[i].exp_rd);
      check($sformatf("vec%0d_if", i), {7'd0, t0if}, {7'd0, vecs[i].exp_if});
      if (vecs[i].t) repeat (3) step(vecs[i].a, 8'h00, 0, 0);
    end

    // Asynchronous reset in the middle of a count
    step(9'h081, 8'h08, 1, 0);
    step(9'h001, 8'hF0, 1, 0);
    for (int i = 0; i < 12; i++) step(9'h001, 8'h00, 0, (i % 4) == 3);
    check("pre_reset_count", dout, 8'hF1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tmr0", dout, 8'h00);
    check("async_rst_if", {7'd0, t0if}, 8'h00);
    addr = 9'h081;
    #1;
    check("async_rst_option", dout, 8'hFF);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 400; i++) begin
      step(9'h001, 8'h00, 0, (i % 4) == 3);
      if (t0if !== 1'b0) check("rst_hold_if", {7'd0, t0if}, 8'h00);
    end
    check("rst_no_count_100_ticks", dout, 8'h00);

    // Randomized traffic against the reference model
    for (int i = 0; i < 1600; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: ra = 9'h001;
        1: ra = 9'h101;
        2: ra = 9'h081;
        3: ra = 9'h181;
        default: ra = 9'($urandom_range(0, 511));
      endcase
      rd = 8'($urandom_range(0, 255));
      if (ra[7:0] == 8'h01 && $urandom_range(0, 1) == 1) rd = rd | 8'hF0;
      if (ra[7:0] == 8'h81 && $urandom_range(0, 3) != 0) rd = rd & 8'hDF;
      if (ra[7:0] == 8'h81 && $urandom_range(0, 1) == 1) rd = (rd & 8'hF8) | 8'h01;
      rw = ($urandom_range(0, 15) == 0);
      rt = (i % 4) == 3;
      step(ra, rd, rw, rt);
      check($sformatf("rand%0d_rd@%03h", i, ra), dout, 8'(model_read(ra)));
      check($sformatf("rand%0d_if", i), {7'd0, t0if}, {7'd0, m_if});
    end

`ifdef TMR0_EXT_CLOCK_EN
    // External clock on falling edges, 4 clocks high and 4 clocks low
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    t0cki = 1'b0;
    step(9'h081, 8'h38, 1, 0);
    check("ext_option", dout, 8'h38);
    addr = 9'h001;
    for (int p = 0; p < 10; p++) begin
      t0cki = 1'b1;
      step(9'h001, 8'h00, 0, 0);
      step(9'h001, 8'h00, 0, 0);
      step(9'h001, 8'h00, 0, 0);
      check($sformatf("ext%0d_rise_no_effect", p), dout, 8'(p));
      step(9'h001, 8'h00, 0, 0);
      t0cki = 1'b0;
      step(9'h001, 8'h00, 0, 0);
      step(9'h001, 8'h00, 0, 0);
      check($sformatf("ext%0d_before_3clk", p), dout, 8'(p));
      step(9'h001, 8'h00, 0, 0);
      check($sformatf("ext%0d_at_3clk", p), dout, 8'(p + 1));
      step(9'h001, 8'h00, 0, 0);
    end
    check("ext_total", dout, 8'h0A);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
